// File: rtl/crc32_pkg.sv
// Shared definitions for the streaming CRC-32 engine: FSM encoding,
// default polynomial/seed/output mask and a bit-reversal helper.
package crc32_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_RESULT = 2'd2
   } crc_state_t;

   localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_XOR_OUT = 32'hFFFFFFFF;

   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational one-byte CRC update. In reflected mode the register is kept in
// the reflected domain, so no output bit reversal is needed downstream.
module crc32_byte_step
   import crc32_pkg::*;
#(
   parameter logic [31:0] POLY    = CRC_POLY,
   parameter int          REFLECT = 1
) (
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   localparam logic [31:0] POLY_R = reflect32(POLY);

   generate
      if (REFLECT != 0) begin : g_refl
         always_comb begin
            logic [31:0] c;
            c       = crc_i;
            c[7:0]  = c[7:0] ^ data_i;
            for (int b = 0; b < 8; b++) begin
               c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
            end
            crc_o = c;
         end
      end else begin : g_norm
         always_comb begin
            logic [31:0] c;
            c        = crc_i;
            c[31:24] = c[31:24] ^ data_i;
            for (int b = 0; b < 8; b++) begin
               c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
            end
            crc_o = c;
         end
      end
   endgenerate

endmodule

// File: rtl/crc32_stream.sv
// Streaming CRC-32: absorbs one DATA_BYTES-wide beat per clock, with a byte-valid
// mask on the final beat, and presents the result behind a valid/ready handshake.
module crc32_stream
   import crc32_pkg::*;
#(
   parameter int          DATA_BYTES = 4,
   parameter logic [31:0] POLY       = CRC_POLY,
   parameter logic [31:0] INIT       = CRC_INIT,
   parameter logic [31:0] XOR_OUT    = CRC_XOR_OUT,
   parameter int          REFLECT    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [8*DATA_BYTES-1:0] in_data,
   input  logic [DATA_BYTES-1:0]   in_keep,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_crc,
   output logic                    busy
);

   crc_state_t                     state_q, state_d;
   logic [31:0]                    crc_q, crc_d;
   logic                           accept;
   logic [DATA_BYTES-1:0]          lane_en;
   logic [DATA_BYTES:0][31:0]      chain;
   logic [DATA_BYTES-1:0][31:0]    step;

   assign in_ready = !start && (state_q != ST_RESULT);
   assign accept   = in_valid && in_ready;

   assign chain[0] = (state_q == ST_IDLE) ? INIT : crc_q;

   // Lanes are enabled up to the first cleared keep bit; keep only matters on the last beat.
   always_comb begin
      logic run;
      run     = 1'b1;
      lane_en = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         run        = run && (!in_last || in_keep[i]);
         lane_en[i] = run;
      end
   end

   generate
      for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane
         crc32_byte_step #(
            .POLY    (POLY),
            .REFLECT (REFLECT)
         ) u_step (
            .crc_i  (chain[g]),
            .data_i (in_data[8*g +: 8]),
            .crc_o  (step[g])
         );
         assign chain[g+1] = lane_en[g] ? step[g] : chain[g];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      if (start) begin
         state_d = ST_IDLE;
         crc_d   = INIT;
      end else begin
         case (state_q)
            ST_IDLE, ST_ACCUM: begin
               if (accept) begin
                  crc_d   = chain[DATA_BYTES];
                  state_d = in_last ? ST_RESULT : ST_ACCUM;
               end
            end
            ST_RESULT: begin
               if (out_ready) begin
                  state_d = ST_IDLE;
                  crc_d   = INIT;
               end
            end
            default: begin
               state_d = ST_IDLE;
               crc_d   = INIT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         crc_q   <= INIT;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
      end
   end

   assign out_valid = (state_q == ST_RESULT);
   assign busy      = (state_q != ST_IDLE);
   assign out_crc   = crc_q ^ XOR_OUT;

endmodule

// File: tb/tb_crc32_stream.sv
// Scoreboard bench for crc32_stream: four instances (1/2/4/8 bytes per beat),
// directed known-answer vectors plus randomized messages against a bitwise model.
module tb_crc32_stream;

   logic clk;
   logic rst;
   logic go_dir, go_rand, rst_ack;
   int   n_tests, n_fail;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, required %b", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] crc_ref(input logic [7:0] m[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (m[i]) begin
         c = c ^ {24'd0, m[i]};
         for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   for (genvar k = 0; k < 4; k++) begin : g
      localparam int DB = 1 << k;
      logic start, in_valid, in_ready, in_last, out_valid, out_ready, busy;
      logic [8*DB-1:0] in_data;
      logic [DB-1:0]   in_keep;
      logic [31:0]     out_crc;
      logic [31:0]     exp_q[$];
      logic rdy_hold, rdy_rand, done_dir, done_rnd, rst_req;

      crc32_stream #(.DATA_BYTES(DB)) dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_data   (in_data),
         .in_keep   (in_keep),
         .in_last   (in_last),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_crc   (out_crc),
         .busy      (busy)
      );

      initial begin
         out_ready = 1'b0;
         forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_hold;
         end
      end

      initial begin
         forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_result_db%0d: got %h, required no result", DB, out_crc);
               end else begin
                  chk($sformatf("crc_db%0d", DB), out_crc, exp_q.pop_front());
               end
            end
         end
      end

      task automatic init_sig();
         start = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
         rdy_hold = 1'b1; rdy_rand = 1'b0; done_dir = 1'b0; done_rnd = 1'b0; rst_req = 1'b0;
      endtask

      task automatic beat(input logic [8*DB-1:0] d, input logic [DB-1:0] kp, input logic lst);
         logic acc;
         in_data = d; in_keep = kp; in_last = lst; in_valid = 1'b1;
         acc = 1'b0;
         for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
         end
         in_valid = 1'b0;
         in_last  = 1'b0;
         if (!acc) chk1($sformatf("beat_accept_db%0d", DB), acc, 1'b1);
      endtask

      task automatic drain();
         int c;
         c = 0;
         while (exp_q.size() != 0 && c < 500) begin
            @(negedge clk);
            c++;
         end
         chk($sformatf("drain_db%0d", DB), 32'(exp_q.size()), 32'd0);
         @(posedge clk);
         #1;
      endtask

      task automatic send_msg(input logic [7:0] msg[$], input bit gaps);
         int len, nb, idx;
         logic [8*DB-1:0] d;
         logic [DB-1:0] kp;
         logic lst;
         len = msg.size();
         nb  = (len + DB - 1) / DB;
         if (nb == 0) nb = 1;
         exp_q.push_back(crc_ref(msg));
         for (int b = 0; b < nb; b++) begin
            lst = (b == nb - 1);
            for (int i = 0; i < DB; i++) begin
               idx = b * DB + i;
               d[8*i +: 8] = (idx < len) ? msg[idx] : 8'($urandom_range(0, 255));
               if (lst) kp[i] = (idx < len) ? 1'b1 : (idx == len) ? 1'b0 : 1'($urandom_range(0, 1));
               else     kp[i] = 1'($urandom_range(0, 1));
            end
            if (gaps) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
            end
            beat(d, kp, lst);
         end
      endtask

      task automatic run_rand();
         logic [7:0] msg[$];
         int len;
         rdy_rand = 1'b1;
         for (int m = 0; m < 20; m++) begin
            len = (m == 0) ? 0 : (m == 1) ? 64 : $urandom_range(0, 64);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
            send_msg(msg, 1'b1);
         end
         drain();
         done_rnd = 1'b1;
      endtask

      if (k == 2) begin : g_dir4
         initial begin
            init_sig();
            wait (go_dir);
            @(posedge clk);
            #1;
            // "123456789" split 4/4/1, with idle cycles inside ACCUM
            exp_q.push_back(32'hCBF43926);
            beat(32'h34333231, 4'b1111, 1'b0);
            repeat (4) begin
               @(negedge clk);
               chk1("accum_hold_busy", busy, 1'b1);
               @(posedge clk);
               #1;
            end
            beat(32'h38373635, 4'b0000, 1'b0);
            beat(32'hA5A5A539, 4'b0001, 1'b1);
            @(negedge clk);
            chk1("latency_valid", out_valid, 1'b1);
            drain();
            // non-contiguous keep stops at the first cleared lane
            exp_q.push_back(32'hCBF43926);
            beat(32'h34333231, 4'b0110, 1'b0);
            beat(32'h38373635, 4'b1111, 1'b0);
            beat(32'hA5A5A539, 4'b1101, 1'b1);
            drain();
            // empty message with result held back
            rdy_hold = 1'b0;
            exp_q.push_back(32'h00000000);
            beat(32'hDEADBEEF, 4'b0000, 1'b1);
            repeat (5) begin
               @(negedge clk);
               chk1("hold_valid", out_valid, 1'b1);
               chk("hold_crc", out_crc, 32'h00000000);
               chk1("hold_in_ready", in_ready, 1'b0);
            end
            @(posedge clk);
            #1;
            rdy_hold = 1'b1;
            drain();
            // abort mid-message; start wins over a concurrent last beat
            beat(32'h34333231, 4'b1111, 1'b0);
            start = 1'b1; in_valid = 1'b1; in_last = 1'b1; in_keep = 4'b1111; in_data = 32'h11223344;
            @(negedge clk);
            chk1("start_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
            start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
            @(negedge clk);
            chk1("abort_idle", busy, 1'b0);
            @(posedge clk);
            #1;
            exp_q.push_back(32'hCBF43926);
            beat(32'h34333231, 4'b1111, 1'b0);
            beat(32'h38373635, 4'b1111, 1'b0);
            beat(32'h00000039, 4'b0001, 1'b1);
            drain();
            // start while a result waits: the result is dropped
            rdy_hold = 1'b0;
            beat(32'hA5636261, 4'b0111, 1'b1);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            rdy_hold = 1'b1;
            repeat (3) begin
               @(negedge clk);
               chk1("drop_no_valid", out_valid, 1'b0);
            end
            @(posedge clk);
            #1;
            // start together with the result handshake: exactly one result
            rdy_hold = 1'b0;
            exp_q.push_back(32'hCBF43926);
            beat(32'h34333231, 4'b1111, 1'b0);
            beat(32'h38373635, 4'b1111, 1'b0);
            beat(32'hFFFFFF39, 4'b0001, 1'b1);
            start = 1'b1;
            rdy_hold = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (4) begin
               @(negedge clk);
               chk1("no_double_valid", out_valid, 1'b0);
            end
            chk("no_double_q", 32'(exp_q.size()), 32'd0);
            @(posedge clk);
            #1;
            // leave a message half-done and ask for an asynchronous reset
            beat(32'h34333231, 4'b1111, 1'b0);
            @(negedge clk);
            chk1("pre_rst_busy", busy, 1'b1);
            @(posedge clk);
            #1;
            rst_req = 1'b1;
            for (int c = 0; c < 20000; c++) begin
               if (rst_ack) break;
               @(posedge clk);
            end
            chk1("rst_ack", rst_ack, 1'b1);
            @(posedge clk);
            #1;
            exp_q.push_back(32'hCBF43926);
            beat(32'h34333231, 4'b1111, 1'b0);
            beat(32'h38373635, 4'b1111, 1'b0);
            beat(32'h00000039, 4'b0001, 1'b1);
            drain();
            done_dir = 1'b1;
            wait (go_rand);
            @(posedge clk);
            #1;
            run_rand();
         end
      end else if (k == 0) begin : g_dir1
         initial begin
            init_sig();
            wait (go_dir);
            @(posedge clk);
            #1;
            exp_q.push_back(32'hD202EF8D);
            beat(8'h00, 1'b1, 1'b1);
            exp_q.push_back(32'h352441C2);
            beat(8'h61, 1'b0, 1'b0);
            beat(8'h62, 1'b0, 1'b0);
            beat(8'h63, 1'b1, 1'b1);
            drain();
            done_dir = 1'b1;
            wait (go_rand);
            @(posedge clk);
            #1;
            run_rand();
         end
      end else begin : g_rnd
         initial begin
            init_sig();
            done_dir = 1'b1;
            wait (go_rand);
            @(posedge clk);
            #1;
            run_rand();
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      go_dir  = 1'b0;
      go_rand = 1'b0;
      rst_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk1("rst_valid_db4", g[2].out_valid, 1'b0);
      chk1("rst_busy_db4", g[2].busy, 1'b0);
      chk("rst_crc_db4", g[2].out_crc, 32'h00000000);
      chk1("rst_in_ready_db1", g[0].in_ready, 1'b1);
      @(negedge clk);
      rst    = 1'b0;
      go_dir = 1'b1;

      for (int c = 0; c < 20000; c++) begin
         if (g[0].done_dir && g[1].done_dir && g[2].rst_req && g[3].done_dir) break;
         @(posedge clk);
      end
      chk1("dir_phase_reached", g[2].rst_req, 1'b1);

      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk1("async_rst_valid", g[2].out_valid, 1'b0);
      chk1("async_rst_busy", g[2].busy, 1'b0);
      chk("async_rst_crc", g[2].out_crc, 32'h00000000);
      @(posedge clk);
      #1;
      chk1("rst_held_busy", g[2].busy, 1'b0);
      @(negedge clk);
      rst     = 1'b0;
      rst_ack = 1'b1;

      for (int c = 0; c < 20000; c++) begin
         if (g[2].done_dir) break;
         @(posedge clk);
      end
      chk1("dir_done_db4", g[2].done_dir, 1'b1);

      go_rand = 1'b1;
      for (int c = 0; c < 40000; c++) begin
         if (g[0].done_rnd && g[1].done_rnd && g[2].done_rnd && g[3].done_rnd) break;
         @(posedge clk);
      end
      chk1("rand_done", g[0].done_rnd && g[1].done_rnd && g[2].done_rnd && g[3].done_rnd, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/crc32_stream.md
CRC32_STREAM -- requirements
Module: crc32_stream

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, bytes per input beat (legal: 1, 2, 4, 8).
REQ-002 SHALL have parameter POLY, default 32'h04C11DB7, generator polynomial in normal form.
REQ-003 SHALL have parameter INIT, default 32'hFFFFFFFF, register value at the start of each message.
REQ-004 SHALL have parameter XOR_OUT, default 32'hFFFFFFFF, value XORed into the result.
REQ-005 SHALL have parameter REFLECT, default 1; 1 means input bytes and output are bit-reflected (Ethernet/zlib CRC-32).
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1 bit, abort: discards the current message and returns to IDLE.
REQ-009 SHALL have port in_valid, input, 1 bit, input beat present.
REQ-010 SHALL have port in_ready, output, 1 bit, beat accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port in_data, input, 8*DATA_BYTES bits; byte lane 0 (bits 7:0) is the first byte in message order.
REQ-012 SHALL have port in_keep, input, DATA_BYTES bits, byte-valid mask, honoured only on the last beat; all other beats are treated as all-ones.
REQ-013 SHALL have port in_last, input, 1 bit, marks the final beat of a message.
REQ-014 SHALL have port out_valid, output, 1 bit, result available.
REQ-015 SHALL have port out_ready, input, 1 bit, result consumed when out_valid and out_ready are both high.
REQ-016 SHALL have port out_crc, output, 32 bits, final CRC (register XOR XOR_OUT).
REQ-017 SHALL have port busy, output, 1 bit, high in ACCUM and RESULT.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, ACCUM, RESULT.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM, 0 in RESULT, and 0 in any cycle where start=1.
REQ-020 A beat accepted in IDLE SHALL be processed from INIT; with in_last=0 the FSM SHALL go to ACCUM, with in_last=1 to RESULT.
REQ-021 A beat accepted in ACCUM SHALL be processed from the running register; with in_last=1 the FSM SHALL go to RESULT.
REQ-022 One full beat (DATA_BYTES bytes) SHALL be absorbed per clock with no bubbles (throughput of 1 beat/cycle).
REQ-023 out_valid SHALL rise on the first cycle after the last beat is accepted (latency 1); out_crc SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 On handshake in RESULT, the FSM SHALL go to IDLE and the register SHALL reload INIT.
REQ-025 On the last beat, in_keep SHALL be contiguous from lane 0; only the kept lanes SHALL be processed.
REQ-026 in_keep=0 on the last beat SHALL give a zero-byte message; in IDLE this SHALL yield INIT^XOR_OUT (0x00000000 with defaults).
REQ-027 A non-contiguous in_keep SHALL be processed up to the first zero lane only.
REQ-028 start=1 in any state SHALL force IDLE and register=INIT on the next edge, SHALL drop any result, and SHALL take priority over in_valid, in_last and out_ready in the same cycle.
REQ-029 in_valid=0 in ACCUM SHALL hold the register and the state indefinitely.

Reset
REQ-030 While rst=1, the block SHALL be asynchronously forced to state=IDLE, register=INIT, out_valid=0, busy=0, and out_crc=INIT^XOR_OUT.
REQ-031 Reset deassertion SHALL take effect at a clock edge; the first beat may be accepted on the first edge after deassertion.

Structure
REQ-032 Shared package crc32_pkg SHALL hold the FSM state encodings and the default constants POLY, INIT and XOR_OUT.
REQ-033 Sub-module crc32_byte_step (combinational: 32-bit crc + 8-bit data -> 32-bit crc, parametrised by POLY and REFLECT) SHALL be instantiated DATA_BYTES times in a chain, with each stage's output muxed by in_keep.

Verification
REQ-034 Defaults, DATA_BYTES=4: "1234","5678", then "9" with keep=0001 and last -> out_crc=0xCBF43926 one cycle after the last beat.
REQ-035 DATA_BYTES=1: single byte 0x00 with last -> 0xD202EF8D; then "abc" over 3 beats -> 0x352441C2, with no idle cycle needed between the two messages.
REQ-036 Empty message: keep=0000 with last in IDLE -> 0x00000000; hold out_ready=0 for 5 cycles -> out_valid and out_crc stable and in_ready=0.
REQ-037 Abort: start pulsed mid-message after "1234", then "123456789" sent -> 0xCBF43926 (the aborted data leaves no trace); start together with the out_ready handshake -> IDLE and no double-result.
REQ-038 rst asserted mid-ACCUM and between clock edges -> outputs reach reset values immediately; a message sent after release matches the reference CRC.
REQ-039 Random in_valid/out_ready gaps, random lengths 0..64 bytes, DATA_BYTES in {1,2,4,8} -> every result matches a software CRC-32 model.
